toggle_event_transmitter: RTL and testbench

Transmit side of the toggle-signalling scheme. Single-cycle event pulses on each channel become transitions of a per-channel level: every accepted event produces exactly one toggle. Toggles on a channel are spaced at least `Hold_Cycles` clocks apart, and events that arrive faster are queued in a saturating per-channel pending counter. A downstream both-edge detector recovers one pulse per toggle.

---
 rtl/toggle_event_transmitter_pkg.sv | 17 +
 rtl/toggle_event_transmitter_if.sv | 28 ++
 rtl/register_variable_width.sv | 21 ++
 rtl/toggle_event_channel.sv | 78 +++++++
 rtl/toggle_event_transmitter.sv | 43 ++++
 tb/tb_toggle_event_transmitter.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/toggle_event_transmitter_pkg.sv
// Shared constants and elaboration helpers for the toggle event transmitter.
package toggle_event_transmitter_pkg;

  // Hold timer width: ceil(log2(hold_cycles)), never less than one bit.
  function automatic int timer_width(input int hold_cycles);
    int width;
    width = 1;
    while ((1 << width) < hold_cycles) width++;
    return width;
  endfunction

  // Parameter legality: both the hold time and the counter width must be positive.
  function automatic bit params_legal(input int hold_cycles, input int count_width);
    return (hold_cycles >= 1) && (count_width >= 1);
  endfunction

endpackage

// File: rtl/toggle_event_transmitter_if.sv
// Event/level bus between a pulse source (master) and the toggle transmitter (slave).
interface toggle_event_transmitter_if #(
  parameter int Width = 1
) ();

  logic [Width-1:0] Pulse_In;
  logic             Ovf_Clr;
  logic [Width-1:0] Level_Out;
  logic [Width-1:0] Pending;
  logic [Width-1:0] Overflow;

  modport master (
    output Pulse_In,
    output Ovf_Clr,
    input  Level_Out,
    input  Pending,
    input  Overflow
  );

  modport slave (
    input  Pulse_In,
    input  Ovf_Clr,
    output Level_Out,
    output Pending,
    output Overflow
  );

endinterface

// File: rtl/register_variable_width.sv
// Generic loadable register with synchronous active-high clear that dominates the load.
module Register_Variable_Width #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             sres,
  input  logic             ld_en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  // Clear wins over load; otherwise capture d when enabled.
  always_ff @(posedge clk) begin
    if (sres) begin
      q <= '0;
    end else if (ld_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/toggle_event_channel.sv
// One transmit channel: backlog counter, hold timer, toggle level and sticky overflow.
module toggle_event_channel
  import toggle_event_transmitter_pkg::*;
#(
  parameter int Hold_Cycles = 4,
  parameter int Count_Width = 3
) (
  input  logic clk,
  input  logic sres,
  input  logic ld_en,
  input  logic pulse,
  input  logic ovf_clr,
  output logic level,
  output logic pending,
  output logic overflow
);

  localparam int TmrWidth = timer_width(Hold_Cycles);
  localparam logic [TmrWidth-1:0]    HoldLoad = TmrWidth'(Hold_Cycles - 1);
  localparam logic [Count_Width-1:0] CntMax   = '1;

  logic [Count_Width-1:0] cnt;
  logic [TmrWidth-1:0]    tmr;
  logic                   lvl;
  logic                   ovf;
  logic                   issue;
  logic                   drop;

  // A toggle goes out whenever the hold has expired and there is work to do.
  assign issue = (tmr == '0) && ((cnt != '0) || pulse);
  // A pulse is lost only when the backlog is full and nothing leaves this cycle.
  assign drop  = pulse && !issue && (cnt == CntMax);

  // Backlog counter and hold timer; both freeze while the global enable is low.
  always_ff @(posedge clk) begin
    if (sres) begin
      cnt <= '0;
      tmr <= '0;
    end else if (ld_en) begin
      if (issue) begin
        tmr <= HoldLoad;
      end else if (tmr != '0) begin
        tmr <= tmr - TmrWidth'(1);
      end
      if (pulse && !issue && !drop) begin
        cnt <= cnt + Count_Width'(1);
      end else if (!pulse && issue) begin
        cnt <= cnt - Count_Width'(1);
      end
    end
  end

  // Sticky overflow: a drop sets it, the clear is honoured even while frozen, set wins.
  always_ff @(posedge clk) begin
    if (sres) begin
      ovf <= 1'b0;
    end else if (ld_en && drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  Register_Variable_Width #(
    .Width (1)
  ) u_level (
    .clk   (clk),
    .sres  (sres),
    .ld_en (ld_en && issue),
    .d     (~lvl),
    .q     (lvl)
  );

  assign level    = lvl;
  assign pending  = (cnt != '0) || (tmr != '0);
  assign overflow = ovf;

endmodule

// File: rtl/toggle_event_transmitter.sv
// Multi-channel toggle event transmitter: one independent channel per bit of the bus.
module toggle_event_transmitter
  import toggle_event_transmitter_pkg::*;
#(
  parameter int Width       = 1,
  parameter int Hold_Cycles = 4,
  parameter int Count_Width = 3
) (
  input  logic                  clk,
  input  logic                  sres,
  input  logic                  ld_en,
  toggle_event_transmitter_if.slave bus
);

  if (!params_legal(Hold_Cycles, Count_Width)) begin : g_illegal_params
    $error("toggle_event_transmitter: Hold_Cycles and Count_Width must both be >= 1");
  end

  logic [Width-1:0] level_vec;
  logic [Width-1:0] pending_vec;
  logic [Width-1:0] overflow_vec;

  for (genvar i = 0; i < Width; i++) begin : g_channel
    toggle_event_channel #(
      .Hold_Cycles (Hold_Cycles),
      .Count_Width (Count_Width)
    ) u_channel (
      .clk      (clk),
      .sres     (sres),
      .ld_en    (ld_en),
      .pulse    (bus.Pulse_In[i]),
      .ovf_clr  (bus.Ovf_Clr),
      .level    (level_vec[i]),
      .pending  (pending_vec[i]),
      .overflow (overflow_vec[i])
    );
  end

  assign bus.Level_Out = level_vec;
  assign bus.Pending   = pending_vec;
  assign bus.Overflow  = overflow_vec;

endmodule

// File: tb/tb_toggle_event_transmitter.sv
// Scoreboard bench: three transmitters (hold 3, 1, 4) share one stimulus stream; a
// behavioural model queues the expected level of every toggle and a both-edge
// detector pops and compares them, alongside directed checks on the hold-3 unit.
module tb_toggle_event_transmitter;

  localparam int NumDut = 3;
  localparam int Width  = 4;
  localparam int CntMax = 3;

  logic             clk = 1'b0;
  logic             sres;
  logic             ld_en;
  logic [Width-1:0] pulse_in;
  logic             ovf_clr;

  int checks = 0;
  int errors = 0;

  int hold_cfg [NumDut] = '{3, 1, 4};

  int m_backlog  [NumDut][Width];
  int m_hold     [NumDut][Width];
  int m_accepted [NumDut][Width];
  bit m_lvl      [NumDut][Width];
  bit m_ovf      [NumDut][Width];
  int recovered  [NumDut][Width];
  bit prev_lvl   [NumDut][Width];
  bit exp_q      [NumDut*Width][$];

  logic [Width-1:0] lvl_obs  [NumDut];
  logic [Width-1:0] pend_obs [NumDut];
  logic [Width-1:0] ovf_obs  [NumDut];

  always #5 clk = ~clk;

  toggle_event_transmitter_if #(.Width(Width)) bus0 ();
  toggle_event_transmitter_if #(.Width(Width)) bus1 ();
  toggle_event_transmitter_if #(.Width(Width)) bus2 ();

  assign bus0.Pulse_In = pulse_in;
  assign bus1.Pulse_In = pulse_in;
  assign bus2.Pulse_In = pulse_in;
  assign bus0.Ovf_Clr  = ovf_clr;
  assign bus1.Ovf_Clr  = ovf_clr;
  assign bus2.Ovf_Clr  = ovf_clr;

  assign lvl_obs[0]  = bus0.Level_Out;
  assign lvl_obs[1]  = bus1.Level_Out;
  assign lvl_obs[2]  = bus2.Level_Out;
  assign pend_obs[0] = bus0.Pending;
  assign pend_obs[1] = bus1.Pending;
  assign pend_obs[2] = bus2.Pending;
  assign ovf_obs[0]  = bus0.Overflow;
  assign ovf_obs[1]  = bus1.Overflow;
  assign ovf_obs[2]  = bus2.Overflow;

  toggle_event_transmitter #(.Width(Width), .Hold_Cycles(3), .Count_Width(2)) dut0 (
    .clk(clk), .sres(sres), .ld_en(ld_en), .bus(bus0.slave));
  toggle_event_transmitter #(.Width(Width), .Hold_Cycles(1), .Count_Width(2)) dut1 (
    .clk(clk), .sres(sres), .ld_en(ld_en), .bus(bus1.slave));
  toggle_event_transmitter #(.Width(Width), .Hold_Cycles(4), .Count_Width(2)) dut2 (
    .clk(clk), .sres(sres), .ld_en(ld_en), .bus(bus2.slave));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Behavioural reference: one backlog/hold/level per channel, pushing the level each toggle should show.
  task automatic model_step(input logic [Width-1:0] p, input bit en, input bit clr, input bit rst);
    for (int k = 0; k < NumDut; k++) begin
      for (int c = 0; c < Width; c++) begin
        bit issue;
        bit drop;
        if (rst) begin
          m_backlog[k][c]  = 0;
          m_hold[k][c]     = 0;
          m_accepted[k][c] = 0;
          m_lvl[k][c]      = 1'b0;
          m_ovf[k][c]      = 1'b0;
          exp_q[k*Width+c].delete();
        end else if (en) begin
          issue = (m_hold[k][c] == 0) && (m_backlog[k][c] > 0 || p[c]);
          drop  = p[c] && !issue && (m_backlog[k][c] == CntMax);
          if (issue) begin
            m_lvl[k][c] = !m_lvl[k][c];
            exp_q[k*Width+c].push_back(m_lvl[k][c]);
            m_hold[k][c] = hold_cfg[k] - 1;
          end else if (m_hold[k][c] > 0) begin
            m_hold[k][c]--;
          end
          if (p[c] && !drop) m_accepted[k][c]++;
          m_backlog[k][c] = m_backlog[k][c] + ((p[c] && !drop) ? 1 : 0) - (issue ? 1 : 0);
          if (drop) m_ovf[k][c] = 1'b1;
          else if (clr) m_ovf[k][c] = 1'b0;
        end else if (clr) begin
          m_ovf[k][c] = 1'b0;
        end
      end
    end
  endtask

  // Drive one cycle, advance the model, then detect edges and compare just after the clock edge.
  task automatic applyStimulus(input logic [Width-1:0] p, input bit en, input bit clr, input bit rst);
    logic [Width-1:0] exp_lvl, exp_pend, exp_ovf;
    bit popped;
    pulse_in = p;
    ld_en    = en;
    ovf_clr  = clr;
    sres     = rst;
    model_step(p, en, clr, rst);
    @(posedge clk);
    #1;
    for (int k = 0; k < NumDut; k++) begin
      for (int c = 0; c < Width; c++) begin
        exp_lvl[c]  = m_lvl[k][c];
        exp_pend[c] = (m_backlog[k][c] > 0) || (m_hold[k][c] > 0);
        exp_ovf[c]  = m_ovf[k][c];
        if (rst) begin
          recovered[k][c] = 0;
          prev_lvl[k][c]  = lvl_obs[k][c];
        end else if (lvl_obs[k][c] !== prev_lvl[k][c]) begin
          recovered[k][c]++;
          if (exp_q[k*Width+c].size() == 0) begin
            checkOutput($sformatf("sb_unexpected_d%0d_c%0d", k, c), 0, 1);
          end else begin
            popped = exp_q[k*Width+c].pop_front();
            checkOutput($sformatf("sb_level_d%0d_c%0d", k, c), lvl_obs[k][c], popped);
          end
          prev_lvl[k][c] = lvl_obs[k][c];
        end
      end
      checkOutput($sformatf("level_d%0d", k), lvl_obs[k], exp_lvl);
      checkOutput($sformatf("pending_d%0d", k), pend_obs[k], exp_pend);
      checkOutput($sformatf("overflow_d%0d", k), ovf_obs[k], exp_ovf);
    end
  endtask

  // Watchdog so a stuck run still ends with a reported failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios on the hold-3 unit, then a random loopback run across all units.
  initial begin
    int snap;
    logic [9:0] burst_exp;
    logic [7:0] freeze_exp;
    logic [Width-1:0] rnd;

    burst_exp  = 10'b1111000111;
    freeze_exp = 8'b11111000;
    pulse_in = '0; ld_en = 1'b1; ovf_clr = 1'b0; sres = 1'b1;

    $display("[TB] reset");
    repeat (2) begin
      applyStimulus(4'hF, 1'b1, 1'b0, 1'b1);
      checkOutput("reset_level", bus0.Level_Out, 0);
      checkOutput("reset_pending", bus0.Pending, 0);
      checkOutput("reset_overflow", bus0.Overflow, 0);
    end
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_level", bus0.Level_Out, 0);
    checkOutput("post_reset_pending", bus0.Pending, 0);
    checkOutput("post_reset_overflow", bus0.Overflow, 0);
    repeat (6) applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] single event");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    checkOutput("single_level0", bus0.Level_Out[0], 1);
    checkOutput("single_others", bus0.Level_Out[3:1], 0);
    checkOutput("single_pending0_a", bus0.Pending[0], 1);
    checkOutput("single_pending_others", bus0.Pending[3:1], 0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("single_pending0_b", bus0.Pending[0], 1);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("single_pending0_c", bus0.Pending[0], 0);
    checkOutput("single_level0_hold", bus0.Level_Out[0], 1);

    $display("[TB] burst");
    snap = recovered[0][1];
    for (int t = 0; t < 10; t++) begin
      applyStimulus((t < 3) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("burst_level_cycle%0d", t + 1), bus0.Level_Out[1], burst_exp[t]);
    end
    checkOutput("burst_toggles", recovered[0][1] - snap, 3);
    checkOutput("burst_overflow", bus0.Overflow[1], 0);

    $display("[TB] overflow");
    snap = recovered[0][2];
    for (int t = 0; t < 6; t++) begin
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
      if (t == 4) checkOutput("ovf_before_drop", bus0.Overflow[2], 0);
      if (t == 5) checkOutput("ovf_after_drop", bus0.Overflow[2], 1);
    end
    repeat (12) applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_toggles", recovered[0][2] - snap, 5);
    checkOutput("ovf_final_level", bus0.Level_Out[2], 1);
    checkOutput("ovf_sticky", bus0.Overflow[2], 1);
    applyStimulus(4'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("ovf_cleared", bus0.Overflow[2], 0);

    $display("[TB] enable freeze");
    repeat (3) applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    snap = recovered[0][3];
    repeat (5) applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("freeze_toggles", recovered[0][3] - snap, 0);
    checkOutput("freeze_level", bus0.Level_Out[3], 1);
    checkOutput("freeze_pending", bus0.Pending[3], 1);
    checkOutput("freeze_overflow", bus0.Overflow[3], 0);
    for (int t = 0; t < 8; t++) begin
      applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("thaw_level_r%0d", t), bus0.Level_Out[3], freeze_exp[t]);
    end
    checkOutput("thaw_toggles", recovered[0][3] - snap, 2);

    $display("[TB] loopback");
    repeat (600) begin
      rnd = 4'($urandom & $urandom);
      applyStimulus(rnd, ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0), 1'b0);
    end
    repeat (40) applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NumDut; k++) begin
      for (int c = 0; c < Width; c++) begin
        checkOutput($sformatf("sb_leftover_d%0d_c%0d", k, c), exp_q[k*Width+c].size(), 0);
        checkOutput($sformatf("recovered_d%0d_c%0d", k, c), recovered[k][c], m_accepted[k][c]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
